// File: rtl/datapath_pkg.sv
// Shared constants for the single-bus datapath slice: data width and ALU op codes.
package datapath_pkg;

    localparam int unsigned WIDTH = 32;

    localparam logic [4:0] ALU_ADD = 5'd0;
    localparam logic [4:0] ALU_MUL = 5'd1;
    localparam logic [4:0] ALU_SUB = 5'd2;
    localparam logic [4:0] ALU_AND = 5'd3;
    localparam logic [4:0] ALU_OR  = 5'd4;
    localparam logic [4:0] ALU_NOT = 5'd5;
    localparam logic [4:0] ALU_NEG = 5'd6;
    localparam logic [4:0] ALU_DIV = 5'd7;

endpackage

// File: rtl/mul_datapath_if.sv
// Control strobes, memory data and observed register contents of the datapath slice.
// The sequencer (master) drives strobes; the datapath (slave) drives the observed values.
interface mul_datapath_if;
    import datapath_pkg::*;

    // Bus-source selects
    logic PCout, Zhighout, Zlowout, MDRout, R2out, R4out;
    // Register load enables
    logic MARin, Zin, PCin, MDRin, IRin, Yin;
    logic R5in, R2in, R4in, HIin, LOin;
    // ALU / memory controls
    logic             IncPC;
    logic             Read;
    logic [4:0]       MUL;
    logic [WIDTH-1:0] Mdatain;
    // Observed state
    logic [WIDTH-1:0] BusMuxOut;
    logic [WIDTH-1:0] MAR_q, IR_q, PC_q, HI_q, LO_q;
    // R5 has no bus driver, so this is the only place its contents can be seen
    logic [WIDTH-1:0] R5_q;

    modport master (
        output PCout, Zhighout, Zlowout, MDRout, R2out, R4out,
        output MARin, Zin, PCin, MDRin, IRin, Yin,
        output R5in, R2in, R4in, HIin, LOin,
        output IncPC, Read, MUL, Mdatain,
        input  BusMuxOut, MAR_q, IR_q, PC_q, HI_q, LO_q, R5_q
    );

    modport slave (
        input  PCout, Zhighout, Zlowout, MDRout, R2out, R4out,
        input  MARin, Zin, PCin, MDRin, IRin, Yin,
        input  R5in, R2in, R4in, HIin, LOin,
        input  IncPC, Read, MUL, Mdatain,
        output BusMuxOut, MAR_q, IR_q, PC_q, HI_q, LO_q, R5_q
    );

endinterface

// File: rtl/datapath_alu.sv
// Combinational ALU: result = Y op Bus, 64 bits wide so a full signed product fits.
// Optional signed divide (quotient low, remainder high) is built only when
// DATAPATH_DIV_EN is defined; otherwise op 7 yields 0.
module datapath_alu
    import datapath_pkg::*;
(
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    input  logic [4:0]         op_i,
    input  logic               inc_i,
    output logic [2*WIDTH-1:0] result_o
);

    localparam logic [WIDTH-1:0] Zero = '0;

    // Sign-extend to 64 bits so an unsigned 64-bit multiply gives the signed product
    logic [2*WIDTH-1:0] a_ext, b_ext, product;
    assign a_ext   = {{WIDTH{a_i[WIDTH-1]}}, a_i};
    assign b_ext   = {{WIDTH{b_i[WIDTH-1]}}, b_i};
    assign product = a_ext * b_ext;

`ifdef DATAPATH_DIV_EN
    logic signed [WIDTH-1:0] a_s, b_s, quo, rem;
    assign a_s = a_i;
    assign b_s = b_i;
    // SV signed division truncates toward zero, so the remainder follows the dividend
    assign quo = a_s / b_s;
    assign rem = a_s % b_s;
`endif

    // Operation select; IncPC overrides the op code
    always_comb begin
        result_o = '0;
        if (inc_i) begin
            result_o = {Zero, b_i + WIDTH'(1)};
        end else begin
            case (op_i)
                ALU_ADD: result_o = {Zero, a_i + b_i};
                ALU_MUL: result_o = product;
                ALU_SUB: result_o = {Zero, a_i - b_i};
                ALU_AND: result_o = {Zero, a_i & b_i};
                ALU_OR:  result_o = {Zero, a_i | b_i};
                ALU_NOT: result_o = {Zero, ~b_i};
                ALU_NEG: result_o = {Zero, Zero - b_i};
`ifdef DATAPATH_DIV_EN
                ALU_DIV: result_o = (b_i == Zero) ? '0 : {rem, quo};
`else
                ALU_DIV: result_o = '0;
`endif
                default: result_o = '0;
            endcase
        end
    end

endmodule

// File: rtl/mul_datapath.sv
// Single-bus 32-bit datapath slice driven by external control strobes.
// Registers PC, IR, MAR, MDR, Y, Z(64), HI, LO, R2, R4, R5 share one bus.
// Build option: DATAPATH_DIV_EN enables the signed divider on ALU op 7.
module mul_datapath
    import datapath_pkg::*;
(
    input  logic           Clock,
    input  logic           Reset,
    mul_datapath_if.slave  dp
);

    logic [WIDTH-1:0]   pc_q, ir_q, mar_q, mdr_q, y_q, hi_q, lo_q;
    logic [WIDTH-1:0]   r2_q, r4_q, r5_q;
    logic [2*WIDTH-1:0] z_q;
    logic [WIDTH-1:0]   bus_mux;
    logic [2*WIDTH-1:0] alu_result;

    // Bus encoder: fixed priority, 0 when nothing drives
    always_comb begin
        bus_mux = '0;
        if (dp.PCout) begin
            bus_mux = pc_q;
        end else if (dp.Zhighout) begin
            bus_mux = z_q[2*WIDTH-1:WIDTH];
        end else if (dp.Zlowout) begin
            bus_mux = z_q[WIDTH-1:0];
        end else if (dp.MDRout) begin
            bus_mux = mdr_q;
        end else if (dp.R2out) begin
            bus_mux = r2_q;
        end else if (dp.R4out) begin
            bus_mux = r4_q;
        end
    end

    datapath_alu u_alu (
        .a_i      (y_q),
        .b_i      (bus_mux),
        .op_i     (dp.MUL),
        .inc_i    (dp.IncPC),
        .result_o (alu_result)
    );

    // Register file: reset wins; bus reads see pre-edge values, giving read-before-write
    always_ff @(posedge Clock) begin
        if (Reset) begin
            pc_q  <= '0;
            ir_q  <= '0;
            mar_q <= '0;
            mdr_q <= '0;
            y_q   <= '0;
            z_q   <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
            r2_q  <= '0;
            r4_q  <= '0;
            r5_q  <= '0;
        end else begin
            if (dp.PCin)  pc_q  <= bus_mux;
            if (dp.IRin)  ir_q  <= bus_mux;
            if (dp.MARin) mar_q <= bus_mux;
            if (dp.Yin)   y_q   <= bus_mux;
            if (dp.HIin)  hi_q  <= bus_mux;
            if (dp.LOin)  lo_q  <= bus_mux;
            if (dp.R2in)  r2_q  <= bus_mux;
            if (dp.R4in)  r4_q  <= bus_mux;
            if (dp.R5in)  r5_q  <= bus_mux;
            if (dp.MDRin) mdr_q <= dp.Read ? dp.Mdatain : bus_mux;
            if (dp.Zin)   z_q   <= alu_result;
        end
    end

    assign dp.BusMuxOut = bus_mux;
    assign dp.MAR_q     = mar_q;
    assign dp.IR_q      = ir_q;
    assign dp.PC_q      = pc_q;
    assign dp.HI_q      = hi_q;
    assign dp.LO_q      = lo_q;
    assign dp.R5_q      = r5_q;

endmodule

// File: tb/tb_mul_datapath.sv
// Bench for mul_datapath: directed register-transfer sequences plus random strobe
// cycles, all compared against a value-level model of the datapath.
module tb_mul_datapath;
    import datapath_pkg::*;

    logic Clock = 1'b0;
    logic Reset;
    always #5 Clock = ~Clock;

    mul_datapath_if dif ();

    mul_datapath dut (
        .Clock (Clock),
        .Reset (Reset),
        .dp    (dif)
    );

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    // Model state
    logic [31:0] m_pc, m_ir, m_mar, m_mdr, m_y, m_hi, m_lo, m_r2, m_r4, m_r5;
    logic [63:0] m_z;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_pc = 0; m_ir = 0; m_mar = 0; m_mdr = 0; m_y = 0;
        m_hi = 0; m_lo = 0; m_r2 = 0; m_r4 = 0; m_r5 = 0; m_z = 0;
    endtask

    function automatic logic [31:0] model_bus();
        if (dif.PCout)    return m_pc;
        if (dif.Zhighout) return m_z[63:32];
        if (dif.Zlowout)  return m_z[31:0];
        if (dif.MDRout)   return m_mdr;
        if (dif.R2out)    return m_r2;
        if (dif.R4out)    return m_r4;
        return 32'h0;
    endfunction

    function automatic logic [63:0] model_alu(input logic [31:0] a, input logic [31:0] b,
                                              input logic [4:0] op, input logic inc);
        int     sa, sb, q, r;
        longint p;
        logic [31:0] w;
        sa = a;
        sb = b;
        if (inc) begin
            w = b + 1;
            return {32'h0, w};
        end
        case (op)
            5'd0: begin w = a + b;  return {32'h0, w}; end
            5'd1: begin p = longint'(sa) * longint'(sb); return p; end
            5'd2: begin w = a - b;  return {32'h0, w}; end
            5'd3: return {32'h0, a & b};
            5'd4: return {32'h0, a | b};
            5'd5: return {32'h0, ~b};
            5'd6: begin w = 0 - b;  return {32'h0, w}; end
`ifdef DATAPATH_DIV_EN
            5'd7: begin
                if (sb == 0) return 64'h0;
                q = sa / sb;
                r = sa % sb;
                return {r, q};
            end
`endif
            default: return 64'h0;
        endcase
    endfunction

    task automatic clear_ctrl();
        Reset = 0;
        dif.PCout = 0; dif.Zhighout = 0; dif.Zlowout = 0; dif.MDRout = 0;
        dif.R2out = 0; dif.R4out = 0;
        dif.MARin = 0; dif.Zin = 0; dif.PCin = 0; dif.MDRin = 0; dif.IRin = 0; dif.Yin = 0;
        dif.R5in = 0; dif.R2in = 0; dif.R4in = 0; dif.HIin = 0; dif.LOin = 0;
        dif.IncPC = 0; dif.Read = 0; dif.MUL = 0; dif.Mdatain = 0;
    endtask

    // One clock with whatever strobes are currently set; checks bus before the edge
    // and visible registers after it, then clears the strobes.
    task automatic do_cycle(input string tag);
        logic [31:0] b;
        logic [63:0] alu;
        #1;
        b   = model_bus();
        alu = model_alu(m_y, b, dif.MUL, dif.IncPC);
        check({tag, ":bus"}, {32'h0, dif.BusMuxOut}, {32'h0, b});
        if (Reset) begin
            model_reset();
        end else begin
            if (dif.PCin)  m_pc  = b;
            if (dif.IRin)  m_ir  = b;
            if (dif.MARin) m_mar = b;
            if (dif.Yin)   m_y   = b;
            if (dif.HIin)  m_hi  = b;
            if (dif.LOin)  m_lo  = b;
            if (dif.R2in)  m_r2  = b;
            if (dif.R4in)  m_r4  = b;
            if (dif.R5in)  m_r5  = b;
            if (dif.MDRin) m_mdr = dif.Read ? dif.Mdatain : b;
            if (dif.Zin)   m_z   = alu;
        end
        @(posedge Clock);
        #1;
        check({tag, ":mar"}, {32'h0, dif.MAR_q}, {32'h0, m_mar});
        check({tag, ":ir"},  {32'h0, dif.IR_q},  {32'h0, m_ir});
        check({tag, ":pc"},  {32'h0, dif.PC_q},  {32'h0, m_pc});
        check({tag, ":hi"},  {32'h0, dif.HI_q},  {32'h0, m_hi});
        check({tag, ":lo"},  {32'h0, dif.LO_q},  {32'h0, m_lo});
        check({tag, ":r5"},  {32'h0, dif.R5_q},  {32'h0, m_r5});
        clear_ctrl();
    endtask

    task automatic peek_bus(input string tag, input logic [31:0] exp);
        #1;
        check(tag, {32'h0, dif.BusMuxOut}, {32'h0, exp});
        clear_ctrl();
    endtask

    // Memory -> MDR -> general register (2, 4 or 5)
    task automatic load_reg(input int which, input logic [31:0] v);
        dif.Mdatain = v; dif.Read = 1; dif.MDRin = 1;
        do_cycle("ld_mdr");
        dif.MDRout = 1;
        if (which == 2) dif.R2in = 1;
        else if (which == 4) dif.R4in = 1;
        else dif.R5in = 1;
        do_cycle("ld_reg");
    endtask

    // Y <- R2; Z <- Y op R4; LO <- Zlow; HI <- Zhigh
    task automatic op_seq(input logic [4:0] op);
        dif.R2out = 1; dif.Yin = 1;
        do_cycle("op_y");
        dif.R4out = 1; dif.MUL = op; dif.Zin = 1;
        do_cycle("op_z");
        dif.Zlowout = 1; dif.LOin = 1;
        do_cycle("op_lo");
        dif.Zhighout = 1; dif.HIin = 1;
        do_cycle("op_hi");
    endtask

    initial begin
        clear_ctrl();
        model_reset();

        // Reset
        Reset = 1;
        @(posedge Clock);
        #1;
        Reset = 0;
        #1;
        check("rst_mar", {32'h0, dif.MAR_q}, 64'h0);
        check("rst_ir",  {32'h0, dif.IR_q},  64'h0);
        check("rst_pc",  {32'h0, dif.PC_q},  64'h0);
        check("rst_hi",  {32'h0, dif.HI_q},  64'h0);
        check("rst_lo",  {32'h0, dif.LO_q},  64'h0);
        check("rst_bus", {32'h0, dif.BusMuxOut}, 64'h0);

        // Register loads
        load_reg(2, 32'h8FFF_FFFF);
        load_reg(4, 32'h0000_0003);
        load_reg(5, 32'h0000_0027);
        dif.R2out = 1; peek_bus("r2_val", 32'h8FFF_FFFF);
        dif.R4out = 1; peek_bus("r4_val", 32'h0000_0003);
        check("r5_val", {32'h0, dif.R5_q}, 64'h27);

        // Fetch from PC=0
        dif.PCout = 1; dif.MARin = 1; dif.IncPC = 1; dif.Zin = 1;
        do_cycle("f1");
        dif.Zlowout = 1; dif.PCin = 1; dif.Read = 1; dif.MDRin = 1;
        dif.Mdatain = 32'h4A92_0000;
        do_cycle("f2");
        dif.MDRout = 1; dif.IRin = 1;
        do_cycle("f3");
        check("fetch_mar", {32'h0, dif.MAR_q}, 64'h0);
        check("fetch_pc",  {32'h0, dif.PC_q},  64'h1);
        check("fetch_ir",  {32'h0, dif.IR_q},  64'h4A92_0000);

        // Signed multiply
        op_seq(ALU_MUL);
        check("mul_lo", {32'h0, dif.LO_q}, 64'hAFFF_FFFD);
        check("mul_hi", {32'h0, dif.HI_q}, 64'hFFFF_FFFE);
        load_reg(2, 32'h0001_0000);
        load_reg(4, 32'h0001_0000);
        op_seq(ALU_MUL);
        check("mul2_lo", {32'h0, dif.LO_q}, 64'h0);
        check("mul2_hi", {32'h0, dif.HI_q}, 64'h1);

        // Bus priority
        dif.PCout = 1; dif.MDRout = 1; peek_bus("prio_pc_mdr", 32'h1);
        peek_bus("bus_idle", 32'h0);

        // Divide (or op 7 as a zero result)
        load_reg(2, 32'hFFFF_FFF9);
        load_reg(4, 32'h0000_0002);
        op_seq(ALU_DIV);
`ifdef DATAPATH_DIV_EN
        check("div_quo", {32'h0, dif.LO_q}, 64'hFFFF_FFFD);
        check("div_rem", {32'h0, dif.HI_q}, 64'hFFFF_FFFF);
`else
        check("div_off_lo", {32'h0, dif.LO_q}, 64'h0);
        check("div_off_hi", {32'h0, dif.HI_q}, 64'h0);
`endif
        load_reg(4, 32'h0);
        op_seq(ALU_DIV);
        check("div0_lo", {32'h0, dif.LO_q}, 64'h0);
        check("div0_hi", {32'h0, dif.HI_q}, 64'h0);

        // Random strobe cycles
        for (int i = 0; i < 600; i++) begin
            Reset        = ($urandom_range(0, 47) == 0);
            dif.PCout    = ($urandom_range(0, 5) == 0);
            dif.Zhighout = ($urandom_range(0, 4) == 0);
            dif.Zlowout  = ($urandom_range(0, 4) == 0);
            dif.MDRout   = ($urandom_range(0, 3) == 0);
            dif.R2out    = ($urandom_range(0, 3) == 0);
            dif.R4out    = ($urandom_range(0, 3) == 0);
            dif.MARin    = ($urandom_range(0, 3) == 0);
            dif.Zin      = ($urandom_range(0, 1) == 0);
            dif.PCin     = ($urandom_range(0, 3) == 0);
            dif.MDRin    = ($urandom_range(0, 2) == 0);
            dif.IRin     = ($urandom_range(0, 3) == 0);
            dif.Yin      = ($urandom_range(0, 2) == 0);
            dif.R5in     = ($urandom_range(0, 3) == 0);
            dif.R2in     = ($urandom_range(0, 3) == 0);
            dif.R4in     = ($urandom_range(0, 3) == 0);
            dif.HIin     = ($urandom_range(0, 3) == 0);
            dif.LOin     = ($urandom_range(0, 3) == 0);
            dif.IncPC    = ($urandom_range(0, 7) == 0);
            dif.Read     = ($urandom_range(0, 1) == 0);
            dif.MUL      = 5'($urandom_range(0, 9));
            dif.Mdatain  = $urandom;
            do_cycle("rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
